// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Program-load writer and fetch port for the instruction memory of the
// single-cycle MIPS core. A framed byte stream arrives on a valid/ready
// handshake. Bytes are assembled into big-endian 32-bit words and written
// into an internal word array. The frame is protected by an XOR checksum.
// The core fetches from the same array through a combinational read port.
//
// Frame: LEN_HI, LEN_LO (word count N), 4*N data bytes (MSB first), CSUM.
//        CSUM = XOR of every byte from LEN_HI through the last data byte.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_valid may drop for any number of cycles. in_ready depends only on the
// loader state, never on in_valid.
//
// Ports:
//   clk          - system clock; all state changes on the rising edge
//   rst          - synchronous active-low reset
//   load_start   - one-cycle pulse that begins a new frame (ignored while busy)
//   in_valid     - in_data holds a valid byte
//   in_data      - stream byte
//   in_ready     - loader accepts a byte this cycle
//   address      - core fetch byte address (PC); bits [1:0] are ignored
//   inst         - fetched instruction; a nop (0) while busy or out of range
//   busy         - a frame is in progress
//   done         - the last frame loaded with a good checksum (sticky)
//   err          - the last frame failed (sticky)
//   words_loaded - words written in the current/last frame
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic [31:0] address,
    output logic [31:0] inst,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // Current state is kept under a plain name so checkers can bind to it.
    state_t state;
    state_t state_next;

    logic [31:0] mem [DEPTH];

    logic [7:0]  len_hi;     // first length byte, held until LEN_LO arrives
    logic [15:0] n_words;    // word count of the current frame
    logic [1:0]  lane;       // byte position inside the current word
    logic [23:0] word_reg;   // first three bytes of the word being assembled
    logic [7:0]  acc;        // running XOR checksum

    logic        accept;
    logic        can_start;
    logic [15:0] len_word;
    logic        last_byte_of_word;
    logic        last_word;
    logic [15:0] wl_plus_one;

    assign accept            = in_valid && in_ready;
    assign can_start         = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    assign len_word          = {len_hi, in_data};
    assign last_byte_of_word = (lane == 2'd3);
    assign wl_plus_one       = words_loaded + 16'd1;
    assign last_word         = (wl_plus_one == n_words);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_start) begin
                    state_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    state_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    // Empty frames go straight to the checksum byte; oversize
                    // frames are rejected before anything is written.
                    if (len_word == 16'd0) begin
                        state_next = S_CSUM;
                    end else if (len_word > 16'(DEPTH)) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && last_byte_of_word && last_word) begin
                    state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_next = (in_data == acc) ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic (state-decoded). done/err are sticky simply because the
    // FSM rests in DONE/ERR until the next load_start or reset.
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state)
            S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: done = 1'b1;
            S_ERR:  err  = 1'b1;
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: length capture, lane counter, word assembly, checksum,
    // word counter.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_hi       <= 8'd0;
            n_words      <= 16'd0;
            lane         <= 2'd0;
            word_reg     <= 24'd0;
            acc          <= 8'd0;
            words_loaded <= 16'd0;
        end else if (can_start) begin
            if (load_start) begin
                lane         <= 2'd0;
                acc          <= 8'd0;
                words_loaded <= 16'd0;
            end
        end else if (accept) begin
            // Every byte except the checksum byte itself feeds the XOR.
            if (state != S_CSUM) begin
                acc <= acc ^ in_data;
            end
            unique case (state)
                S_LEN_HI: len_hi <= in_data;
                S_LEN_LO: n_words <= len_word;
                S_DATA: begin
                    lane     <= lane + 2'd1;
                    word_reg <= {word_reg[15:0], in_data};
                    if (last_byte_of_word) begin
                        words_loaded <= wl_plus_one;
                    end
                end
                default: begin
                    lane <= lane;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Word array. Not reset: a program survives a reset, and a partially
    // loaded frame leaves its completed words behind.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst && accept && (state == S_DATA) && last_byte_of_word) begin
            mem[words_loaded[ADDR_W-1:0]] <= {word_reg, in_data};
        end
    end

    // -----------------------------------------------------------------------
    // Fetch port. Returns a nop while a load is running so the core never
    // executes a half-written program, and for any PC beyond the array.
    // -----------------------------------------------------------------------
    logic in_range;
    logic unused_addr_bits;

    assign in_range         = (address[31:ADDR_W+2] == '0);
    assign unused_addr_bits = ^address[1:0];

    always_comb begin
        inst = 32'h0000_0000;
        if (!busy && in_range) begin
            inst = mem[address[ADDR_W+1:2]];
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program-load writer for the instruction memory read by the single-cycle MIPS core.
- Accepts a framed byte stream on a valid/ready handshake and assembles big-endian 32-bit words into an internal word array.
- Checks the frame with an XOR checksum and reports status.
- Serves the core's instruction fetch port (address -> inst) from the same array.

Parameters:
- DEPTH, 256, number of 32-bit instruction words stored.
- ADDR_W, 8, word-index width; must satisfy 2**ADDR_W == DEPTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets).
- load_start  input  1  one-cycle pulse to begin a new frame.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- address  input  32  core fetch byte address (PC).
- inst  output  32  fetched instruction word.
- busy  output  1  frame in progress.
- done  output  1  last frame loaded with good checksum (sticky).
- err  output  1  last frame failed (sticky).
- words_loaded  output  16  words written in the current/last frame.

Behaviour:
- Frame format: LEN_HI, LEN_LO (word count N, big-endian), then 4*N data bytes (each word MSB first), then one CSUM byte.
- CSUM = XOR of every byte from LEN_HI through the last data byte.
- Byte transfer: a byte is accepted at a rising edge with in_valid && in_ready. in_valid may gap arbitrarily; there are no timeouts.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- in_ready = 1 only in LEN_HI, LEN_LO, DATA, CSUM.
- busy = 1 in the same four states.
- Reset: state=IDLE; in_ready=0, busy=0, done=0, err=0, words_loaded=0; byte counter=0, checksum accumulator=0. Array contents are NOT cleared by reset.
- load_start handling:
  - In IDLE, DONE or ERR: go to LEN_HI; clear done, err, words_loaded, accumulator and byte counter.
  - While busy: ignored.
- LEN_HI: accept -> LEN_LO.
- LEN_LO: accept -> evaluate N:
  - N == 0: go to CSUM.
  - N > DEPTH: go to ERR, err=1, no writes.
  - Otherwise: go to DATA.
- DATA:
  - A 2-bit byte lane counter shifts bytes into a word register.
  - On acceptance of the 4th byte, the word is written to array[words_loaded] at that same edge, and words_loaded increments.
  - When words_loaded reaches N: go to CSUM.
- CSUM: accept -> compare with accumulator.
  - Equal: DONE, done=1.
  - Unequal: ERR, err=1.
  - Words already written remain in the array.
- DONE/ERR: hold until load_start or reset.
- Fetch (combinational):
  - inst = array[address[ADDR_W+1:2]] when busy==0 and address[31:ADDR_W+2]==0.
  - Otherwise inst = 32'h00000000 (MIPS nop).
  - address[1:0] is ignored.
- A word written at edge k is visible on inst after that edge (once busy drops).
- Reset mid-frame: return to IDLE, done=0, err=0; partial words persist in the array.
- Simultaneous reset and load_start: reset wins.

Test Plan:
- Good frame: send 00 02 20 08 00 05 01 09 50 20 57 -> done=1, err=0, words_loaded=2; inst=0x20080005 at address 0x0 and 0x01095020 at address 0x4; inst=0 at 0x8 before any earlier load.
- Empty frame: 00 00 00 -> DONE with words_loaded=0, no array change; a second good frame afterwards loads normally.
- Oversize frame: 01 01 -> ERR right after LEN_LO, err=1, in_ready=0, array unchanged; load_start recovers to LEN_HI.
- Bad checksum: good frame with CSUM 0x58 -> err=1, done=0; both words still readable at 0x0/0x4.
- Handshake: in_valid toggled every other cycle, plus load_start pulsed mid-DATA -> identical result to the good-frame case and the pulse is ignored; busy=1 causes inst=0 during load.
- Reset mid-DATA after 5 data bytes: rst=0 for one cycle -> IDLE, busy=0, words_loaded=0, first word 0x20080005 retained at 0x0.
